seq_skip_subtractor: RTL
========================

SEQ_SKIP_SUBTRACTOR -- requirements
Module: seq_skip_subtractor

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits, SHALL be a multiple of BLOCK.
REQ-002 Parameter BLOCK, default 4: bits processed per cycle by the internal carry-skip stage.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  a/b hold a valid operand pair.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  WIDTH  minuend.
REQ-008 b  input  WIDTH  subtrahend.
REQ-009 out_valid  output  1  diff/borrow hold a valid result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-012 borrow  output  1  1 when unsigned a < b.
REQ-013 ovf  output  1  signed overflow, present only when SEQ_SKIP_SUB_OVF_EN is defined.

Function
REQ-014 FSM states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE, out_valid 1 only in DONE.
REQ-015 IDLE: on in_valid && in_ready, latch a and b, clear block index k to 0, set running carry to 1, go to RUN.
REQ-016 Subtraction SHALL be computed as a + ~b + 1, one BLOCK-bit slice per RUN cycle, LSB slice first.
REQ-017 Per slice: ripple sum of a_k + ~b_k + carry; propagate p = a_k ^ ~b_k; slice carry-out = carry-in if all p bits are 1, else the ripple carry-out.
REQ-018 The slice sum SHALL be written into diff bits [k*BLOCK +: BLOCK]; the slice carry-out SHALL become the running carry for slice k+1.
REQ-019 After slice WIDTH/BLOCK-1, borrow = ~final carry and the FSM goes to DONE; out_valid SHALL rise exactly WIDTH/BLOCK cycles after the accepting edge (8 for defaults).
REQ-020 DONE: diff, borrow and ovf SHALL remain stable while out_valid && !out_ready.
REQ-021 DONE with out_ready = 1: go to IDLE on that edge; in_ready rises the following cycle (no same-cycle accept from DONE).
REQ-022 in_valid while not in IDLE SHALL be ignored; a and b changes during RUN SHALL NOT affect the result.
REQ-023 diff SHALL be cleared to 0 on acceptance so partial results are never presented as valid.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, in_ready = 1, out_valid = 0, diff = 0, borrow = 0, ovf = 0, k = 0, carry = 1.
REQ-025 Reset asserted during RUN or DONE SHALL abort the operation; no result for that operand pair SHALL ever be presented.
REQ-026 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro SEQ_SKIP_SUB_OVF_EN defined: port ovf exists; in DONE ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using latched operands.
REQ-028 Macro not defined: port ovf and its logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-029 a=0x00000005, b=0x00000003 -> out_valid 8 cycles after accept, diff=0x00000002, borrow=0.
REQ-030 a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow=1; ovf=0 when enabled.
REQ-031 a=b=0x12345678 (every slice full-propagate, skip path on all 8 slices) -> diff=0x00000000, borrow=0.
REQ-032 a=0x80000000, b=0x00000001 with SEQ_SKIP_SUB_OVF_EN -> diff=0x7FFFFFFF, borrow=0, ovf=1.
REQ-033 out_ready held 0 for 5 cycles in DONE -> diff/borrow stable, in_ready=0, new in_valid ignored; result drains on out_ready=1, then next pair accepted.
REQ-034 rst_n pulsed low at RUN slice 3 -> outputs at reset values immediately, no out_valid afterwards; next pair a=0x00000010, b=0x00000001 -> diff=0x0000000F.

Source files
------------

// File: rtl/seq_skip_subtractor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_skip_subtractor : a - b computed BLOCK bits per cycle with carry-skip.
// Optional: define SEQ_SKIP_SUB_OVF_EN to add the signed-overflow port ovf.
// Rev 1.0
// ---------------------------------------------------------------------------
module seq_skip_subtractor #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SEQ_SKIP_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int              NSLICE     = WIDTH / BLOCK;
  localparam int              KW         = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0]   K_LAST     = KW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({BLOCK{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             borrow_q, borrow_d, carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;

  logic [31:0]      sh;
  logic [WIDTH-1:0] a_shift, b_shift;
  logic [BLOCK-1:0] a_slice, nb_slice, prop;
  logic [BLOCK:0]   ripple;
  logic             slice_cout;

  // Current slice: ripple add of a_k + ~b_k + carry, bypassed when all bits propagate.
  always_comb begin
    sh         = 32'(k_q) * 32'(BLOCK);
    a_shift    = a_q >> sh;
    b_shift    = b_q >> sh;
    a_slice    = a_shift[BLOCK-1:0];
    nb_slice   = ~b_shift[BLOCK-1:0];
    ripple     = {1'b0, a_slice} + {1'b0, nb_slice} + {{BLOCK{1'b0}}, carry_q};
    prop       = a_slice ^ nb_slice;
    slice_cout = (&prop) ? carry_q : ripple[BLOCK];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    carry_d   = carry_q;
    k_d       = k_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          diff_d   = '0;
          borrow_d = 1'b0;
          carry_d  = 1'b1;
          k_d      = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d  = (diff_q & ~(SLICE_MASK << sh)) | (WIDTH'(ripple[BLOCK-1:0]) << sh);
        carry_d = slice_cout;
        if (k_q == K_LAST) begin
          borrow_d = ~slice_cout;
          state_d  = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      carry_q  <= 1'b1;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      carry_q  <= carry_d;
      k_q      <= k_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

`ifdef SEQ_SKIP_SUB_OVF_EN
  assign ovf = (state_q == DONE) && (a_q[WIDTH-1] != b_q[WIDTH-1])
               && (diff_q[WIDTH-1] != a_q[WIDTH-1]);
`endif

endmodule
`default_nettype wire
